// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM states, address width and ACK/NACK bus levels.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } i2c_state_e;

    // Open-drain enable needed to put the given level on SDA.
    function automatic logic drive_low(input logic lvl);
        return lvl == I2C_ACK;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Input synchroniser plus one history FF; reports level and single-cycle edges.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Shift the async pin through the chain; clear to 1 to match an idle bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_target_byte_rx.sv
// I2C target byte receiver: START/STOP detect, address match, MSB-first shift, ACK drive.
module i2c_target_byte_rx
    import i2c_pkg::*;
#(
    parameter int SIZE        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    input  logic                  sda_in,
    input  logic [I2C_ADDR_W-1:0] addr,
    output logic                  sda_oe,
    output logic [SIZE-1:0]       data,
    output logic                  data_valid,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  busy
);

    // Shift register must hold a full address byte even if SIZE is narrower.
    localparam int SR_W  = (SIZE > I2C_ADDR_W + 1) ? SIZE : I2C_ADDR_W + 1;
    localparam int CNT_W = $clog2(SR_W);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst_n(rst_n), .din(scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst_n(rst_n), .din(sda_in),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full_q, full_d;   // byte complete, waiting for the SCL fall
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [SIZE-1:0]   data_d;
    logic              oe_d, busy_d, dv_d, sd_d, pd_d;

    // SCL high in both samples (no SCL edge this cycle) qualifies an SDA edge.
    logic start_c, stop_c, last_bit, addr_hit;
    assign start_c  = sda_fall & scl_lvl & ~scl_rise;
    assign stop_c   = sda_rise & scl_lvl & ~scl_rise;
    assign last_bit = (state_q == ADDR) ? (cnt_q == CNT_W'(I2C_ADDR_W))
                                        : (cnt_q == CNT_W'(SIZE - 1));
    assign addr_hit = (sr_q[I2C_ADDR_W:1] == addr) && (sr_q[0] == 1'b0);

    // Next-state and output decode; START/STOP override any SCL activity.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        sr_d    = sr_q;
        data_d  = data;
        oe_d    = sda_oe;
        busy_d  = busy;
        dv_d    = 1'b0;
        sd_d    = 1'b0;
        pd_d    = 1'b0;
        if (start_c) begin
            state_d = ADDR;
            cnt_d   = '0;
            full_d  = 1'b0;
            oe_d    = drive_low(I2C_NACK);
            busy_d  = 1'b1;
            sd_d    = 1'b1;
        end else if (stop_c) begin
            state_d = IDLE;
            cnt_d   = '0;
            full_d  = 1'b0;
            oe_d    = drive_low(I2C_NACK);
            busy_d  = 1'b0;
            pd_d    = 1'b1;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    if (scl_rise && !full_q) begin
                        sr_d = {sr_q[SR_W-2:0], sda_lvl};
                        if (last_bit) begin
                            cnt_d  = '0;
                            full_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (scl_fall && full_q) begin
                        full_d = 1'b0;
                        if (state_q == ADDR) begin
                            // Only a write to our own address is acknowledged.
                            if (addr_hit) begin
                                state_d = ADDR_ACK;
                                oe_d    = drive_low(I2C_ACK);
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else begin
                            data_d  = sr_q[SIZE-1:0];
                            dv_d    = 1'b1;
                            state_d = DATA_ACK;
                            oe_d    = drive_low(I2C_ACK);
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        state_d = DATA;
                        oe_d    = drive_low(I2C_NACK);
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            sr_q       <= '0;
            sda_oe     <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            sr_q       <= sr_d;
            sda_oe     <= oe_d;
            data       <= data_d;
            data_valid <= dv_d;
            start_det  <= sd_d;
            stop_det   <= pd_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_target_byte_rx.sv
// Randomised bench: bus-level master, transaction-level expectation queue, event monitor.
module tb_i2c_target_byte_rx;

    localparam int         SIZE = 8;
    localparam logic [6:0] OWN  = 7'h2A;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            scl   = 1'b1;
    logic            m_sda = 1'b1;
    logic            sda_bus;
    logic [6:0]      addr  = OWN;
    logic            sda_oe, data_valid, start_det, stop_det, busy;
    logic [SIZE-1:0] data;

    int total = 0;
    int bad   = 0;

    // kind: 0 START, 1 STOP, 2 DATA byte
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } evt_t;

    evt_t       exp_q[$];
    logic [7:0] dbuf[4];
    logic [7:0] last_data = 8'h00;

    // Open-drain bus: either side can pull SDA low.
    assign sda_bus = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_byte_rx #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_bus), .addr(addr),
        .sda_oe(sda_oe), .data(data), .data_valid(data_valid),
        .start_det(start_det), .stop_det(stop_det), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] v);
        evt_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic mon_evt(input logic [1:0] k, input logic [7:0] v);
        evt_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_evt: got kind %0d val %0h want none", k, v);
        end else begin
            e = exp_q.pop_front();
            chk("evt_kind", 32'(k), 32'(e.kind));
            if (k == 2'd2) chk("evt_data", 32'(v), 32'(e.val));
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (start_det)  mon_evt(2'd0, 8'h00);
        if (stop_det)   mon_evt(2'd1, 8'h00);
        if (data_valid) mon_evt(2'd2, data);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bus primitives; each begins and ends mid-way through SCL low (or bus idle).
    task automatic do_start();
        push(2'd0, 8'h00);
        if (!scl) begin
            m_sda = 1'b1; tick(20); scl = 1'b1; tick(20);
        end
        m_sda = 1'b0; tick(20); scl = 1'b0; tick(20);
    endtask

    task automatic do_stop();
        push(2'd1, 8'h00);
        m_sda = 1'b0; tick(20); scl = 1'b1; tick(20); m_sda = 1'b1; tick(20);
    endtask

    task automatic send_bit(input logic b, input bit simul);
        if (simul) begin
            m_sda = ~b; tick(20); m_sda = b; scl = 1'b1;
        end else begin
            m_sda = b; tick(20); scl = 1'b1;
        end
        tick(40); scl = 1'b0; tick(20);
    endtask

    task automatic send_byte(input logic [7:0] v, input int simul_idx);
        for (int i = 7; i >= 0; i--) send_bit(v[i], i == simul_idx);
    endtask

    task automatic ack_slot(input logic exp_oe, input string name);
        m_sda = 1'b1; tick(20); scl = 1'b1; tick(20);
        chk(name, 32'(sda_oe), 32'(exp_oe));
        chk("busy_in_xfer", 32'(busy), 32'd1);
        tick(20); scl = 1'b0; tick(20);
    endtask

    // One transaction: the reference decides ACK and expected bytes from the address rule.
    task automatic xfer(input logic [7:0] ab, input int n, input int partial,
                        input bit stop, input int simul_idx);
        logic ack;
        ack = (ab[7:1] == OWN) && !ab[0];
        do_start();
        send_byte(ab, simul_idx);
        ack_slot(ack, "addr_ack");
        for (int i = 0; i < n; i++) begin
            if (ack) begin
                push(2'd2, dbuf[i]);
                last_data = dbuf[i];
            end
            send_byte(dbuf[i], -1);
            ack_slot(ack, "data_ack");
        end
        for (int i = 0; i < partial; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        if (stop) begin
            do_stop();
            tick(5);
            chk("busy_after_stop", 32'(busy), 32'd0);
            chk("data_hold", 32'(data), 32'(last_data));
            chk("sb_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ab;
        int         r, n, si;
        bit         rs;

        rst_n = 1'b0;
        tick(3);
        chk("rst_oe",    32'(sda_oe),     32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_data",  32'(data),       32'd0);
        chk("rst_dv",    32'(data_valid), 32'd0);
        chk("rst_start", 32'(start_det),  32'd0);
        chk("rst_stop",  32'(stop_det),   32'd0);
        rst_n = 1'b1;
        tick(10);

        // Own-address write with one data byte.
        dbuf[0] = 8'hAA;
        xfer(8'h54, 1, 0, 1'b1, -1);

        // Address mismatch: nothing acknowledged, data ignored.
        dbuf[0] = 8'h11;
        xfer(8'h56, 1, 0, 1'b1, -1);

        // Read of own address: NACK, following byte ignored.
        dbuf[0] = 8'h77;
        xfer(8'h55, 1, 0, 1'b1, -1);

        // Partial byte abandoned by a repeated START.
        xfer(8'h54, 0, 3, 1'b0, -1);
        dbuf[0] = 8'h3C;
        xfer(8'h54, 1, 0, 1'b1, -1);

        // Reset while the target is pulling SDA in a data ACK slot.
        do_start();
        send_byte(8'h54, -1);
        ack_slot(1'b1, "t5_addr_ack");
        push(2'd2, 8'h5A);
        send_byte(8'h5A, -1);
        chk("t5_oe_before_rst", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        tick(1);
        chk("t5_rst_oe",   32'(sda_oe), 32'd0);
        chk("t5_rst_busy", 32'(busy),   32'd0);
        chk("t5_rst_data", 32'(data),   32'd0);
        rst_n     = 1'b1;
        last_data = 8'h00;
        m_sda = 1'b1; tick(20); scl = 1'b1; tick(40);
        chk("t5_sb_drained", 32'(exp_q.size()), 32'd0);
        dbuf[0] = 8'hC3;
        xfer(8'h54, 1, 0, 1'b1, -1);

        // SDA falls in the same cycle SCL rises: a data bit, not a START.
        dbuf[0] = 8'h96;
        xfer(8'h54, 1, 0, 1'b1, 3);

        // Randomised transactions.
        for (int t = 0; t < 10; t++) begin
            r  = int'($urandom_range(0, 3));
            ab = (r == 0) ? 8'h54 : (r == 1) ? 8'h55
                 : {7'($urandom_range(0, 127)), 1'($urandom_range(0, 1))};
            n  = int'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) == 0) && (t != 9);
            si = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
            xfer(ab, n, rs ? int'($urandom_range(1, 7)) : 0, !rs, si);
        end

        tick(10);
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
